mem_responder: RTL
==================

# mem_responder

Memory-side responder for the z23 memory controller: accepts single read/write requests on the `mem_read_en`/`mem_write_en` strobes, holds them for a configurable number of wait states, then returns a one-cycle `cmp_o` completion with `next_data` for reads. It sits on the far side of the controller's completion logic, which turns `cmp_o` into `ack` and the CPU-visible `data_output`. It is backed by an internal word-addressed storage array and is used both as the on-chip scratch memory and as the bench memory model.

## Interface
- `ADDR_W`, 8: word-address width; the array holds 2^ADDR_W 16-bit words.
- `WAIT_STATES`, 2: cycles inserted between request capture and completion; legal range 0–15.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mem_read_en` input 1: read request; held by the requester until the cycle after `cmp_o`.
- `mem_write_en` input 1: write request; same hold rule as `mem_read_en`.
- `mem_addr` input ADDR_W: word address, sampled at capture.
- `mem_wdata` input 16: write data, sampled at capture.
- `cmp_o` output 1: completion pulse, high for exactly one cycle per request.
- `next_data` output 16: read data; valid only while `cmp_o` is high on a read, 0 otherwise.
- `busy` output 1: high from the cycle after capture through the `cmp_o` cycle.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - If `mem_read_en | mem_write_en` is high, capture `op`, `mem_addr` and `mem_wdata` at the edge.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT, or directly to DONE when `WAIT_STATES == 0`.
- **WAIT**
  - Decrement the counter each cycle.
  - On the edge where the counter equals 1, go to DONE.
  - Request inputs are ignored; changes have no effect.
- **Edge entering DONE**
  - Read: `next_data <= mem[addr_q]`.
  - Write: `mem[addr_q] <= wdata_q`; `next_data` stays 0.
- **DONE**
  - `cmp_o = 1`.
  - Next edge: `cmp_o` and `next_data` clear to 0 and the FSM goes to IDLE unconditionally, even if enables are still high.
- Both enables high at capture: treated as a read. No write is performed. This matches the completion logic's read priority.
- Enables low in IDLE: no state change, outputs stay 0.
- Requester contract: enables may drop only after seeing `cmp_o`. A request is re-captured in IDLE only if the enables are still high there, which is a requester protocol error. The bench flags it; the DUT serves it as a new request.
- Reset values: state IDLE, counter 0, `cmp_o` 0, `next_data` 0, `busy` 0, captured registers 0.
- Array contents are not reset.
- Reset mid-operation:
  - Asserted in WAIT: aborts; no write is committed and no `cmp_o` is produced.
  - Asserted in DONE: the already-committed write persists.

## Timing
- Request high in IDLE cycle 0 → captured at the end of cycle 0 → `cmp_o` high in cycle `WAIT_STATES+1`.
- `WAIT_STATES=0`: `cmp_o` in cycle 1.
- `next_data` is registered and aligned exactly with `cmp_o`. The completion logic consumes both combinationally in that same cycle.
- Minimum request spacing is `WAIT_STATES+2` cycles, because one IDLE cycle follows every DONE.
- A write to address A followed by a read of A returns the new data: the write commits at DONE entry, before the next capture.
- Counter width is 4 bits. Counter arithmetic never wraps because the counter is loaded only in IDLE and decremented only in WAIT with a value ≥1.

## Structure
- Shared package `z23_mem_pkg` holds:
  - `mem_state_t` enum (IDLE, WAIT, DONE);
  - `mem_op_t` enum (OP_READ, OP_WRITE);
  - `WAIT_CNT_W = 4`.
- Sub-module `mem_responder_array`:
  - parameterised by `ADDR_W`;
  - synchronous write port (`we`, `waddr`, `wdata`) and combinational read port (`raddr`, `rdata`);
  - no reset.
- Top level holds the FSM, the wait counter, the capture registers and the output registers.

## Test plan
- **Reset:** assert `rst` mid-cycle (asynchronous) → `cmp_o=0`, `next_data=0`, `busy=0` immediately; FSM in IDLE.
- **Write then read:**
  - Write `addr=0x12`, `wdata=0xBEEF` → `cmp_o` one cycle in cycle 3 (WAIT_STATES=2), `next_data=0`.
  - Then read `0x12` → `cmp_o` in cycle 3 with `next_data=0xBEEF`, which is 0 again the next cycle.
- **Zero wait states:** instance with `WAIT_STATES=0`; read of `0x00` after writing `0x1234` → `cmp_o` in cycle 1, `next_data=0x1234`.
- **Simultaneous enables:** `mem_read_en=mem_write_en=1`, `addr=0x05` holding `0xA5A5`, `wdata=0x0000` → `next_data=0xA5A5`; a follow-up read still returns `0xA5A5`.
- **Input change during WAIT:** change `mem_addr` from `0x20` to `0x21` during WAIT → the response reflects `0x20`. Enables held one cycle past `cmp_o` → a second capture occurs and is flagged by the bench.
- **Reset mid-operation:** write `0x7777` to `0x30` (previously `0x1111`), assert `rst` in WAIT → no `cmp_o`; a later read of `0x30` returns `0x1111`.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for the z23 memory responder: FSM states, operation codes
// and the wait-state counter width.
package z23_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_responder_array.sv
// Word-addressed 16-bit storage: synchronous write, combinational read.
// Contents are deliberately not reset so reset never disturbs stored data.
module mem_responder_array #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [2**ADDR_W];

  // Commit a write on the clock edge when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one read/write request, waits
// WAIT_STATES cycles, then pulses cmp_o for one cycle (with read data).
//
// Handshake: a request is taken in IDLE whenever mem_read_en or
// mem_write_en is high (read wins if both are high). The requester holds
// the enables until it sees cmp_o; they are ignored in WAIT and DONE.
// cmp_o is high for exactly one cycle and next_data is valid only then.
module mem_responder
  import z23_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic              cmp_o,
  output logic [15:0]       next_data,
  output logic              busy,
  output mem_state_t        o_dbg_state
);

  localparam logic [WAIT_CNT_W-1:0] WS_LOAD   = WAIT_CNT_W'(WAIT_STATES);
  localparam bit                    ZERO_WAIT = (WAIT_STATES == 0);

  mem_state_t              r_state;
  logic [WAIT_CNT_W-1:0]   r_cnt;
  mem_op_t                 r_op;
  logic [ADDR_W-1:0]       r_addr;
  logic [15:0]             r_wdata;
  logic                    r_cmp;
  logic [15:0]             r_next_data;
  logic                    r_busy;

  logic                    w_req;
  logic                    w_idle;
  logic                    w_enter_done;
  mem_op_t                 w_op;
  logic [ADDR_W-1:0]       w_addr;
  logic [15:0]             w_wdata;
  logic                    w_we;
  logic [15:0]             w_rdata;

  assign w_req  = mem_read_en | mem_write_en;
  assign w_idle = (r_state == IDLE);

  // With zero wait states DONE is entered on the capture edge itself, so the
  // access must use the live inputs rather than the capture registers.
  assign w_op    = w_idle ? (mem_read_en ? OP_READ : OP_WRITE) : r_op;
  assign w_addr  = w_idle ? mem_addr  : r_addr;
  assign w_wdata = w_idle ? mem_wdata : r_wdata;

  assign w_enter_done = (w_idle && w_req && ZERO_WAIT) ||
                        ((r_state == WAIT) && (r_cnt == WAIT_CNT_W'(1)));
  assign w_we = w_enter_done && (w_op == OP_WRITE);

  mem_responder_array #(.ADDR_W(ADDR_W)) u_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_addr),
    .i_wdata (w_wdata),
    .i_raddr (w_addr),
    .o_rdata (w_rdata)
  );

  // Request FSM with wait counter, capture registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= OP_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cmp       <= 1'b0;
      r_next_data <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op    <= w_op;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_cnt   <= WS_LOAD;
            r_busy  <= 1'b1;
            r_state <= ZERO_WAIT ? DONE : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - WAIT_CNT_W'(1);
          if (r_cnt == WAIT_CNT_W'(1)) r_state <= DONE;
        end
        DONE: begin
          r_cmp       <= 1'b0;
          r_next_data <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_enter_done) begin
        r_cmp       <= 1'b1;
        r_next_data <= (w_op == OP_READ) ? w_rdata : 16'h0000;
      end
    end
  end

  assign cmp_o       = r_cmp;
  assign next_data   = r_next_data;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule
